// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter
// Purpose  : Round-robin sharing of one MII transmit path between NUM_REQ
//            nibble-stream sources. Adds preamble/SFD, streams the frame,
//            then holds the inter-frame gap. Owner starvation mid-frame
//            truncates the frame and drains the rest of it.
// Options  : ETH_TX_MAXLEN_EN - abort frames reaching MAX_NIBBLES data
//            nibbles without a last marker (err_oversize stays 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter #(
    parameter int N           = 4,
    parameter int NUM_REQ     = 2,
    parameter int IFG_CYCLES  = 24,
    parameter int MAX_NIBBLES = 3036
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*N-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [N-1:0]           eth_txd,
    output logic                   eth_txen,
    output logic                   busy,
    output logic                   err_underrun,
    output logic                   err_oversize
);

    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW1     = IW + 1;
    localparam int PRE_LEN = 15;
    localparam int TW      = $clog2(((IFG_CYCLES > PRE_LEN) ? IFG_CYCLES : PRE_LEN) + 1);

    localparam logic [TW-1:0] PRE_LAST = TW'(PRE_LEN - 1);
    localparam logic [TW-1:0] IFG_LAST = TW'(IFG_CYCLES);
    localparam logic [N-1:0]  NIB_PRE  = N'(4'h5);
    localparam logic [N-1:0]  NIB_SFD  = N'(4'hD);
    localparam logic [11:0]   CNT_SAT  = 12'hFFF;
    localparam logic [11:0]   LEN_MAX  = 12'(MAX_NIBBLES);

`ifdef ETH_TX_MAXLEN_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SFD   = 3'd2,
        S_DATA  = 3'd3,
        S_DRAIN = 3'd4,
        S_IFG   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [11:0]          cnt_q, cnt_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [N-1:0]         txd_q, txd_d;
    logic                 txen_q, txen_d;
    logic                 und_q, und_d;
    logic                 ovs_q, ovs_d;

    logic [IW-1:0]        w_rr_next;
    logic [IW-1:0]        w_arb_base;
    logic [IW1-1:0]       w_sum;
    logic [IW-1:0]        w_arb_idx;
    logic                 w_arb_found;
    logic                 w_owner_rdy;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [N-1:0]         w_sel_data;
    logic [11:0]          w_cnt_inc;
    logic                 w_len_abort;
    logic                 w_start;

    // Pointer the next arbitration starts from once the current owner finishes.
    assign w_rr_next  = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    // At IFG exit the pointer is being advanced in the same edge, so look ahead.
    assign w_arb_base = (state_q == S_IFG) ? w_rr_next : rr_q;
    assign w_owner_rdy = (state_q == S_SFD) || (state_q == S_DATA) || (state_q == S_DRAIN);
    assign w_cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 12'd1;
    assign w_len_abort = LIMIT_EN && (w_cnt_inc == LEN_MAX);

    // First valid requester at or after the base pointer, wrapping.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, w_arb_base} + IW1'(k);
            if (w_sum >= IW1'(NUM_REQ)) begin
                w_sum = w_sum - IW1'(NUM_REQ);
            end
            if (req_valid[w_sum[IW-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_sum[IW-1:0];
            end
        end
    end

    // Owner's stream selection and per-requester ready (only the owner sees it).
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IW'(i)) begin
                w_sel_valid  = req_valid[i];
                w_sel_last   = req_last[i];
                w_sel_data   = req_data[i*N +: N];
                req_ready[i] = w_owner_rdy;
            end
        end
    end

    // Next-state and registered-output values; MII outputs track the state entered.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        txd_d   = '0;
        txen_d  = 1'b0;
        und_d   = 1'b0;
        ovs_d   = 1'b0;
        w_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_arb_found) begin
                    w_start = 1'b1;
                end
            end
            S_PRE: begin
                txen_d = 1'b1;
                if (tmr_q == PRE_LAST) begin
                    state_d = S_SFD;
                    txd_d   = NIB_SFD;
                    tmr_d   = '0;
                end else begin
                    txd_d = NIB_PRE;
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_SFD, S_DATA: begin
                if (!w_sel_valid) begin
                    state_d = S_DRAIN;
                    und_d   = 1'b1;
                end else begin
                    cnt_d  = w_cnt_inc;
                    txen_d = 1'b1;
                    txd_d  = w_sel_data;
                    if (w_sel_last) begin
                        // Timer starts at 0: the last nibble occupies the first IFG cycle.
                        state_d = S_IFG;
                        tmr_d   = '0;
                    end else if (w_len_abort) begin
                        state_d = S_DRAIN;
                        ovs_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DRAIN: begin
                if (w_sel_valid && w_sel_last) begin
                    // Line already idle here, so every IFG cycle counts toward the gap.
                    state_d = S_IFG;
                    tmr_d   = TW'(1);
                end
            end
            S_IFG: begin
                if (tmr_q == IFG_LAST) begin
                    rr_d = w_rr_next;
                    if (w_arb_found) begin
                        w_start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (w_start) begin
            state_d            = S_PRE;
            grant_d            = '0;
            grant_d[w_arb_idx] = 1'b1;
            gidx_d             = w_arb_idx;
            tmr_d              = '0;
            cnt_d              = '0;
            txen_d             = 1'b1;
            txd_d              = NIB_PRE;
        end
    end

    // State and output registers; reset cuts any frame in flight immediately.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            txd_q   <= '0;
            txen_q  <= 1'b0;
            und_q   <= 1'b0;
            ovs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            und_q   <= und_d;
            ovs_q   <= ovs_d;
        end
    end

    assign grant        = grant_q;
    assign eth_txd      = txd_q;
    assign eth_txen     = txen_q;
    assign busy         = (state_q != S_IDLE);
    assign err_underrun = und_q;
    assign err_oversize = ovs_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_arbiter
// Purpose  : Directed self-checking bench for eth_tx_arbiter (2 requesters,
//            MAX_NIBBLES=10 so ETH_TX_MAXLEN_EN builds exercise the abort).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arbiter;

    localparam int NR   = 2;
    localparam int MAXC = 256;
    localparam int SL   = 32;

    logic          clk;
    logic          rst_b;
    logic [NR-1:0] req_valid;
    logic [NR*4-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] grant;
    logic [3:0]    eth_txd;
    logic          eth_txen;
    logic          busy;
    logic          err_underrun;
    logic          err_oversize;

    int checks = 0;
    int errors = 0;

    // source model: per-requester nibble list with one optional stall point
    logic [3:0] s_dat  [NR][SL];
    bit         s_last [NR][SL];
    int         s_len  [NR];
    int         s_pos  [NR];
    int         s_stall_at   [NR];
    int         s_stall_left [NR];
    bit         acc    [NR];

    // per-cycle trace sampled on the falling edge
    logic       tr_txen  [MAXC];
    logic [3:0] tr_txd   [MAXC];
    logic [1:0] tr_grant [MAXC];
    logic [1:0] tr_ready [MAXC];
    logic       tr_busy  [MAXC];
    logic       tr_und   [MAXC];
    logic       tr_ovs   [MAXC];

    eth_tx_arbiter #(
        .N(4), .NUM_REQ(NR), .IFG_CYCLES(24), .MAX_NIBBLES(10)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .eth_txd(eth_txd), .eth_txen(eth_txen), .busy(busy),
        .err_underrun(err_underrun), .err_oversize(err_oversize)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_src();
        for (int r = 0; r < NR; r++) begin
            s_len[r] = 0; s_pos[r] = 0;
            s_stall_at[r] = -1; s_stall_left[r] = 0;
            acc[r] = 1'b0;
        end
        req_valid = '0; req_last = '0; req_data = '0;
    endtask

    task automatic add_frame(input int r, input int first, input int n);
        for (int j = 0; j < n; j++) begin
            s_dat[r][s_len[r]]  = 4'(first + j);
            s_last[r][s_len[r]] = (j == n - 1);
            s_len[r]++;
        end
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        clear_src();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    // Each falling edge: retire the nibble taken at the last rising edge, drive the next, record outputs.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (acc[r]) s_pos[r]++;
                if (s_pos[r] == s_stall_at[r] && s_stall_left[r] > 0) begin
                    s_stall_left[r]--;
                    req_valid[r] = 1'b0; req_last[r] = 1'b0; req_data[r*4 +: 4] = 4'h0;
                end else if (s_pos[r] < s_len[r]) begin
                    req_valid[r] = 1'b1;
                    req_last[r]  = s_last[r][s_pos[r]];
                    req_data[r*4 +: 4] = s_dat[r][s_pos[r]];
                end else begin
                    req_valid[r] = 1'b0; req_last[r] = 1'b0; req_data[r*4 +: 4] = 4'h0;
                end
            end
            tr_txen[c] = eth_txen; tr_txd[c] = eth_txd; tr_grant[c] = grant;
            tr_ready[c] = req_ready; tr_busy[c] = busy;
            tr_und[c] = err_underrun; tr_ovs[c] = err_oversize;
            for (int r = 0; r < NR; r++) acc[r] = req_valid[r] & req_ready[r];
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        clear_src();
        #2;
        rst_b = 1'b0;
        #1;
        checks++; if (eth_txen !== 1'b0) begin errors++; $display("FAIL reset_txen got %b exp 0", eth_txen); end
        checks++; if (eth_txd !== 4'h0) begin errors++; $display("FAIL reset_txd got %h exp 0", eth_txd); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL reset_und got %b exp 0", err_underrun); end
        checks++; if (err_oversize !== 1'b0) begin errors++; $display("FAIL reset_ovs got %b exp 0", err_oversize); end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_single_frame();
        logic       ee;
        logic [3:0] ed;
        logic [1:0] eg, er;
        do_reset();
        add_frame(0, 1, 8);
        run(52);
        for (int c = 0; c < 52; c++) begin
            ee = (c >= 1 && c <= 24);
            ed = (c >= 1 && c <= 15) ? 4'h5 : (c == 16) ? 4'hD : (c >= 17 && c <= 24) ? 4'(c - 16) : 4'h0;
            eg = (c >= 1 && c <= 48) ? 2'b01 : 2'b00;
            er = (c >= 16 && c <= 23) ? 2'b01 : 2'b00;
            checks++;
            if (tr_txen[c] !== ee || tr_txd[c] !== ed) begin
                errors++; $display("FAIL single_tx c=%0d got en=%b d=%h exp en=%b d=%h", c, tr_txen[c], tr_txd[c], ee, ed);
            end
            checks++;
            if (tr_grant[c] !== eg || tr_busy[c] !== (eg != 2'b00)) begin
                errors++; $display("FAIL single_grant c=%0d got g=%b busy=%b exp g=%b", c, tr_grant[c], tr_busy[c], eg);
            end
            checks++;
            if (tr_ready[c] !== er) begin
                errors++; $display("FAIL single_ready c=%0d got %b exp %b", c, tr_ready[c], er);
            end
        end
    endtask

    task automatic test_contention();
        int b, zeros;
        logic [1:0] eg;
        do_reset();
        add_frame(0, 1, 4); add_frame(0, 1, 4);
        add_frame(1, 9, 4); add_frame(1, 9, 4);
        run(180);
        for (int f = 0; f < 4; f++) begin
            b  = 1 + 44 * f;
            eg = (f % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (tr_grant[b] !== eg || tr_grant[b + 43] !== eg) begin
                errors++; $display("FAIL cont_grant f=%0d got %b/%b exp %b", f, tr_grant[b], tr_grant[b + 43], eg);
            end
            checks++;
            if (tr_txen[b - 1] !== 1'b0 || tr_txen[b] !== 1'b1 || tr_txd[b] !== 4'h5) begin
                errors++; $display("FAIL cont_start f=%0d got en=%b,%b d=%h exp en=0,1 d=5", f, tr_txen[b - 1], tr_txen[b], tr_txd[b]);
            end
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (tr_txd[b + 16 + j] !== 4'((f % 2 == 0 ? 1 : 9) + j)) begin
                    errors++; $display("FAIL cont_data f=%0d j=%0d got %h exp %h", f, j, tr_txd[b + 16 + j], 4'((f % 2 == 0 ? 1 : 9) + j));
                end
            end
            if (f > 0) begin
                zeros = 0;
                for (int c = b - 44; c < b; c++) if (tr_txen[c] === 1'b0) zeros++;
                checks++;
                if (zeros != 24) begin
                    errors++; $display("FAIL cont_gap f=%0d got %0d idle cycles exp 24", f, zeros);
                end
            end
        end
        checks++;
        if (tr_grant[177] !== 2'b00 || tr_busy[177] !== 1'b0) begin
            errors++; $display("FAIL cont_end got g=%b busy=%b exp 00/0", tr_grant[177], tr_busy[177]);
        end
        for (int c = 0; c < 180; c++) begin
            checks++;
            if ((tr_ready[c] & ~tr_grant[c]) !== 2'b00) begin
                errors++; $display("FAIL cont_ready_other c=%0d got ready=%b grant=%b", c, tr_ready[c], tr_grant[c]);
            end
        end
    endtask

    task automatic test_underrun();
        logic       ee;
        logic [3:0] ed;
        logic [1:0] eg, er;
        do_reset();
        add_frame(1, 1, 6);
        s_stall_at[1] = 3; s_stall_left[1] = 5;
        run(54);
        for (int c = 0; c < 54; c++) begin
            ee = (c >= 1 && c <= 19);
            ed = (c >= 1 && c <= 15) ? 4'h5 : (c == 16) ? 4'hD : (c >= 17 && c <= 19) ? 4'(c - 16) : 4'h0;
            eg = (c >= 1 && c <= 50) ? 2'b10 : 2'b00;
            er = (c >= 16 && c <= 26) ? 2'b10 : 2'b00;
            checks++;
            if (tr_txen[c] !== ee || tr_txd[c] !== ed) begin
                errors++; $display("FAIL under_tx c=%0d got en=%b d=%h exp en=%b d=%h", c, tr_txen[c], tr_txd[c], ee, ed);
            end
            checks++;
            if (tr_und[c] !== (c == 20) || tr_ovs[c] !== 1'b0) begin
                errors++; $display("FAIL under_err c=%0d got und=%b ovs=%b exp und=%b ovs=0", c, tr_und[c], tr_ovs[c], (c == 20));
            end
            checks++;
            if (tr_grant[c] !== eg || tr_busy[c] !== (eg != 2'b00) || tr_ready[c] !== er) begin
                errors++; $display("FAIL under_ctl c=%0d got g=%b busy=%b rdy=%b exp g=%b rdy=%b", c, tr_grant[c], tr_busy[c], tr_ready[c], eg, er);
            end
        end
    endtask

    task automatic test_oversize();
        int nsent, ovs_at, idle_at;
        logic       ee;
        logic [3:0] ed;
`ifdef ETH_TX_MAXLEN_EN
        nsent = 10; ovs_at = 26; idle_at = 52;
`else
        nsent = 12; ovs_at = -1; idle_at = 53;
`endif
        do_reset();
        add_frame(0, 1, 12);
        run(70);
        for (int c = 0; c < 70; c++) begin
            ee = (c >= 1 && c <= 16 + nsent);
            ed = (c >= 1 && c <= 15) ? 4'h5 : (c == 16) ? 4'hD : (c >= 17 && c <= 16 + nsent) ? 4'(c - 16) : 4'h0;
            checks++;
            if (tr_txen[c] !== ee || tr_txd[c] !== ed) begin
                errors++; $display("FAIL ovs_tx c=%0d got en=%b d=%h exp en=%b d=%h", c, tr_txen[c], tr_txd[c], ee, ed);
            end
            checks++;
            if (tr_ovs[c] !== (c == ovs_at) || tr_und[c] !== 1'b0) begin
                errors++; $display("FAIL ovs_err c=%0d got ovs=%b und=%b exp ovs=%b und=0", c, tr_ovs[c], tr_und[c], (c == ovs_at));
            end
        end
        checks++;
        if (tr_busy[idle_at - 1] !== 1'b1 || tr_busy[idle_at] !== 1'b0) begin
            errors++; $display("FAIL ovs_idle got busy=%b,%b exp 1,0 at c=%0d", tr_busy[idle_at - 1], tr_busy[idle_at], idle_at);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        add_frame(0, 1, 2);
        run(45);
        clear_src();
        add_frame(0, 1, 2); add_frame(1, 9, 2);
        run(5);
        checks++;
        if (tr_grant[4] !== 2'b10 || tr_txen[4] !== 1'b1) begin
            errors++; $display("FAIL mrst_pre got g=%b en=%b exp g=10 en=1", tr_grant[4], tr_txen[4]);
        end
        #2;
        rst_b = 1'b0;
        #1;
        checks++;
        if (eth_txen !== 1'b0 || eth_txd !== 4'h0 || grant !== 2'b00 || req_ready !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL mrst_async got en=%b d=%h g=%b rdy=%b busy=%b exp all 0", eth_txen, eth_txd, grant, req_ready, busy);
        end
        @(negedge clk);
        rst_b = 1'b1;
        clear_src();
        add_frame(0, 1, 2); add_frame(1, 9, 2);
        run(4);
        checks++;
        if (tr_grant[1] !== 2'b01 || tr_txen[1] !== 1'b1 || tr_txd[1] !== 4'h5) begin
            errors++; $display("FAIL mrst_regrant got g=%b en=%b d=%h exp g=01 en=1 d=5", tr_grant[1], tr_txen[1], tr_txd[1]);
        end
    endtask

    task automatic test_back_to_back();
        int zeros;
        do_reset();
        add_frame(0, 1, 3); add_frame(0, 4, 3);
        run(64);
        zeros = 0;
        for (int c = 20; c < 44; c++) if (tr_txen[c] === 1'b0) zeros++;
        checks++;
        if (zeros != 24 || tr_txen[19] !== 1'b1 || tr_txd[19] !== 4'h3) begin
            errors++; $display("FAIL b2b_gap got %0d idle, tail en=%b d=%h exp 24 idle, tail 1/3", zeros, tr_txen[19], tr_txd[19]);
        end
        checks++;
        if (tr_grant[43] !== 2'b01 || tr_grant[44] !== 2'b01 || tr_busy[43] !== 1'b1 || tr_busy[44] !== 1'b1) begin
            errors++; $display("FAIL b2b_grant got g=%b,%b busy=%b,%b exp 01,01 1,1", tr_grant[43], tr_grant[44], tr_busy[43], tr_busy[44]);
        end
        for (int c = 44; c <= 58; c++) begin
            checks++;
            if (tr_txen[c] !== 1'b1 || tr_txd[c] !== 4'h5) begin
                errors++; $display("FAIL b2b_pre c=%0d got en=%b d=%h exp 1/5", c, tr_txen[c], tr_txd[c]);
            end
        end
        checks++;
        if (tr_txd[59] !== 4'hD) begin
            errors++; $display("FAIL b2b_sfd got %h exp d", tr_txd[59]);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (tr_txen[60 + j] !== 1'b1 || tr_txd[60 + j] !== 4'(4 + j)) begin
                errors++; $display("FAIL b2b_data j=%0d got en=%b d=%h exp 1/%h", j, tr_txen[60 + j], tr_txd[60 + j], 4'(4 + j));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_underrun();
        test_oversize();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares the single MII transmit path (eth_txd / eth_txctl) between NUM_REQ frame sources, e.g. game-state sender and ARP/ack responder.
- Picks sources round-robin, prepends preamble+SFD, streams frame nibbles, then enforces the inter-frame gap.
- Sits between the network_stack TX producers and the PHY pins in top_level; runs on the 25 MHz eth_txck domain.

Parameters:
- N, 4, MII data width in bits per cycle; fixed at 4 (nibble) for this block.
- NUM_REQ, 2, number of requesters (2..8).
- IFG_CYCLES, 24, idle cycles after each frame (96 bit times at 4 bits/cycle).
- MAX_NIBBLES, 3036, payload nibble limit; used only with ETH_TX_MAXLEN_EN.

Ports:
- clk  in  1  TX clock (eth_txck domain).
- rst_b  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester nibble valid.
- req_data  in  NUM_REQ*N  per-requester nibble; requester i uses bits [i*N +: N]; low nibble of each byte first.
- req_last  in  NUM_REQ  marks the final nibble of a frame, FCS included.
- req_ready  out  NUM_REQ  per-requester accept.
- grant  out  NUM_REQ  one-hot owner of the current frame; 0 when idle.
- eth_txd  out  N  MII transmit data, registered.
- eth_txen  out  1  MII transmit enable (eth_txctl), registered.
- busy  out  1  high in every state except IDLE.
- err_underrun  out  1  one-cycle pulse when the owner starves mid-frame.
- err_oversize  out  1  one-cycle pulse on length abort; tied 0 without the macro.

Behaviour:
- Reset (async, rst_b=0): eth_txen=0, eth_txd=0, req_ready=0, grant=0, busy=0, both error outputs 0, rr pointer=0, state=IDLE. Takes effect immediately; a frame in flight is cut with no tail.
- State machine: IDLE -> PRE -> SFD -> DATA -> IFG -> IDLE. Error branch: SFD or DATA -> DRAIN -> IFG.
- IDLE:
  - If any req_valid is high at edge t, grant the first valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
  - grant is registered at t+1. State goes to PRE.
- PRE: eth_txen=1, eth_txd=4'h5 for 15 cycles (t+1..t+15). req_ready=0.
- SFD: eth_txen=1, eth_txd=4'hD for 1 cycle (t+16).
  - req_ready[g]=1 combinationally, where g is the granted index.
  - The first data nibble is accepted here.
- DATA: req_ready[g]=1. A nibble accepted at edge k appears on eth_txd with eth_txen=1 at k+1. Latency is 1 cycle.
- Last nibble: on an accepted nibble with req_last=1, go to IFG. That nibble still drives eth_txen=1 for one cycle.
- IFG: eth_txen=0, eth_txd=0, req_ready=0 for exactly IFG_CYCLES cycles.
  - grant stays held during IFG.
  - On exit: grant=0, rr pointer=(g+1) mod NUM_REQ, state=IDLE.
  - A requester that is valid in the exit cycle can be granted on the next edge.
- Underrun: in SFD or DATA with req_valid[g]=0 at the edge:
  - eth_txen=0 from the next cycle.
  - err_underrun pulses for 1 cycle. State goes to DRAIN.
  - MII cannot stall, so the truncated frame fails FCS at the receiver.
- DRAIN: req_ready[g]=1. Nibbles are discarded with eth_txen=0. The accepted nibble with req_last=1 moves the state to IFG.
- Non-granted requesters always see req_ready=0. Their req_valid may stay high indefinitely.
- Simultaneous requests: arbitration is strictly round-robin. No requester wins twice in a row while another is valid.
- Nibble counter: 12 bits, saturating, cleared in IDLE.

Optional Feature:
- Macro: ETH_TX_MAXLEN_EN.
- Defined: when the DATA nibble count reaches MAX_NIBBLES without req_last:
  - eth_txen drops the next cycle.
  - err_oversize pulses for 1 cycle.
  - State goes to DRAIN, then IFG.
- Undefined: there is no length limit and err_oversize is tied to 0.

Test Plan:
- Single frame:
  - Stimulus: reset, release, req 0 sends 8 nibbles 1..8 with last on 8.
  - Response: eth_txen high for 24 cycles carrying 15×5, D, 1..8. Then 24 cycles low. grant=01 throughout; busy low after IFG.
- Contention:
  - Stimulus: req 0 and req 1 both continuously valid with 4-nibble frames.
  - Response: grants alternate 01,10,01,10. Every gap between frames is exactly 24 cycles with eth_txen=0.
- Underrun:
  - Stimulus: req 1 drops valid after 3 data nibbles, later resumes and sends last.
  - Response: eth_txen falls 1 cycle after the gap and err_underrun pulses once. Remaining nibbles are drained with eth_txen=0, then 24 IFG cycles follow.
- Mid-frame reset:
  - Stimulus: assert rst_b=0 during PRE between clock edges.
  - Response: eth_txen=0, grant=0, req_ready=0 without waiting for an edge. The next grant goes to req 0.
- Oversize (ETH_TX_MAXLEN_EN, MAX_NIBBLES=10):
  - Stimulus: a 12-nibble frame.
  - Response: 10 data nibbles are transmitted, err_oversize pulses, and the last 2 are drained. Without the macro, all 12 are transmitted and err_oversize stays 0.
- Back-to-back single requester:
  - Stimulus: req 0 keeps valid high across frames.
  - Response: re-granted on the cycle after IFG exit. The preamble restarts at 15×5.
